// File: rtl/ipml_fifo_wr_arb_v1_0.sv
`default_nettype none
// ============================================================================
// Module   : ipml_fifo_wr_arb_v1_0
// Brief    : Round-robin, burst-locked arbiter in front of a SYN prefetch FIFO
//            write port. Optional idle watchdog: IPML_WR_ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ipml_fifo_wr_arb_v1_0 #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int ID_W   = 2,
   parameter int TO_CYC = 255,
   parameter int TO_W   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          s_valid,
   input  logic [N_REQ*DATA_W-1:0]   s_data,
   input  logic [N_REQ-1:0]          s_last,
   output logic [N_REQ-1:0]          s_ready,
   output logic [DATA_W-1:0]         fifo_wr_data,
   output logic                      fifo_wr_en,
   input  logic                      fifo_wr_vld,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      timeout_err
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_grant_id;
   logic [ID_W-1:0]   w_winner;
   logic              w_lock;
   logic              w_g_valid;
   logic              w_g_last;
   logic              w_timeout;

   generate
      if ((TO_CYC < 1) || (TO_CYC >= (1 << TO_W)) || ((1 << ID_W) < N_REQ)) begin : g_cfg_chk
         $error("ipml_fifo_wr_arb_v1_0: invalid TO_CYC/TO_W/ID_W for N_REQ");
      end
   endgenerate

   // First valid requester at or after ptr+1, wrapping modulo N_REQ.
   function automatic logic [ID_W-1:0] f_pick(input logic [N_REQ-1:0] v,
                                              input logic [ID_W-1:0]  ptr);
      int idx;
      f_pick = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % N_REQ;
         if (v[idx]) f_pick = ID_W'(idx);
      end
   endfunction

   always_comb begin
      w_lock       = (r_state == S_LOCK);
      w_winner     = f_pick(s_valid, r_rr_ptr);
      w_g_valid    = 1'b0;
      w_g_last     = 1'b0;
      fifo_wr_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant_id == ID_W'(i)) begin
            w_g_valid    = s_valid[i];
            w_g_last     = s_last[i];
            fifo_wr_data = s_data[i*DATA_W +: DATA_W];
         end
      end
      // Reset aborts a burst in the same cycle, so nothing is written then.
      s_ready    = '0;
      fifo_wr_en = 1'b0;
      if (w_lock && !rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) s_ready[i] = fifo_wr_vld;
         end
         fifo_wr_en = w_g_valid & fifo_wr_vld;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (|s_valid) w_state_nxt = S_LOCK;
         S_LOCK: if ((fifo_wr_en && w_g_last) || w_timeout) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr   <= ID_W'(N_REQ - 1);
         r_grant_id <= '0;
      end else if ((r_state == S_IDLE) && (|s_valid)) begin
         r_rr_ptr   <= w_winner;
         r_grant_id <= w_winner;
      end
   end

`ifdef IPML_WR_ARB_WATCHDOG_EN
   logic [TO_W-1:0] r_wd_cnt;
   logic            r_timeout_err;

   // Only owner silence counts; a full FIFO with the owner valid is not idle.
   assign w_timeout = w_lock && !w_g_valid && (r_wd_cnt == TO_W'(TO_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         if (!w_lock || w_g_valid || w_timeout) begin
            r_wd_cnt <= '0;
         end else begin
            r_wd_cnt <= r_wd_cnt + TO_W'(1);
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign grant_id = r_grant_id;
   assign busy     = w_lock;

endmodule
`default_nettype wire

// File: tb/tb_ipml_fifo_wr_arb_v1_0.sv
`default_nettype none
// Testbench for ipml_fifo_wr_arb_v1_0: directed vector table, watchdog
// sequence (when built with the macro), and a randomized model comparison.
module tb_ipml_fifo_wr_arb_v1_0;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int IW = 2;
   localparam int TO = 20;
   localparam int TW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      s_valid;
   logic [N*DW-1:0]   s_data;
   logic [N-1:0]      s_last;
   logic [N-1:0]      s_ready;
   logic [DW-1:0]     fifo_wr_data;
   logic              fifo_wr_en;
   logic              fifo_wr_vld;
   logic [IW-1:0]     grant_id;
   logic              busy;
   logic              timeout_err;

   ipml_fifo_wr_arb_v1_0 #(
      .N_REQ(N), .DATA_W(DW), .ID_W(IW), .TO_CYC(TO), .TO_W(TW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .fifo_wr_data(fifo_wr_data), .fifo_wr_en(fifo_wr_en), .fifo_wr_vld(fifo_wr_vld),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic          rst;
      logic [N-1:0]  v;
      logic [N-1:0]  l;
      logic          wv;
      logic [7:0]    dat;
      logic [N-1:0]  e_rdy;
      logic          e_wen;
      logic [IW-1:0] e_g;
      logic          e_busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [N-1:0] v, input logic [N-1:0] l,
                      input logic wv, input logic [7:0] dat, input logic [N-1:0] e_rdy,
                      input logic e_wen, input logic [IW-1:0] e_g, input logic e_busy);
      vec_t t;
      t.rst = r; t.v = v; t.l = l; t.wv = wv; t.dat = dat;
      t.e_rdy = e_rdy; t.e_wen = e_wen; t.e_g = e_g; t.e_busy = e_busy;
      tbl.push_back(t);
   endtask

   // Requester i presents {i, 16'h0, dat}, so the granted source is visible in the data.
   task automatic drive_data(input logic [7:0] dat);
      for (int i = 0; i < N; i++) s_data[i*DW +: DW] = {8'(i), 16'h0000, dat};
   endtask

   // Random-phase reference: per-requester burst progress plus arbiter ownership.
   int owner, m_grant, m_last, cand;
   int rem[N], bnum[N], beat[N];
   bit pres[N];
   logic [N-1:0]  e_rdy;
   logic          e_wen;
   logic [DW-1:0] e_data;

   initial begin
      rst = 1'b1; s_valid = '0; s_last = '0; s_data = '0; fifo_wr_vld = 1'b1;

      // reset state
      add(1, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 0, 0);
      // req1 3-beat burst
      add(0, 4'b0010, 4'b0000, 1, 8'h01, 4'b0000, 0, 0, 0);
      add(0, 4'b0010, 4'b0000, 1, 8'h01, 4'b0010, 1, 1, 1);
      add(0, 4'b0010, 4'b0000, 1, 8'h02, 4'b0010, 1, 1, 1);
      add(0, 4'b0010, 4'b0010, 1, 8'h03, 4'b0010, 1, 1, 1);
      add(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 1, 0);
      // reset, then req0/2/3 compete with 2-beat bursts
      add(1, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 1, 0);
      add(0, 4'b1101, 4'b0000, 1, 8'h10, 4'b0000, 0, 0, 0);
      add(0, 4'b1101, 4'b0000, 1, 8'h10, 4'b0001, 1, 0, 1);
      add(0, 4'b1101, 4'b0001, 1, 8'h11, 4'b0001, 1, 0, 1);
      add(0, 4'b1100, 4'b0000, 1, 8'h12, 4'b0000, 0, 0, 0);
      add(0, 4'b1100, 4'b0000, 1, 8'h12, 4'b0100, 1, 2, 1);
      add(0, 4'b1100, 4'b0100, 1, 8'h13, 4'b0100, 1, 2, 1);
      add(0, 4'b1000, 4'b0000, 1, 8'h14, 4'b0000, 0, 2, 0);
      add(0, 4'b1000, 4'b0000, 1, 8'h14, 4'b1000, 1, 3, 1);
      add(0, 4'b1000, 4'b1000, 1, 8'h15, 4'b1000, 1, 3, 1);
      add(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 3, 0);
      // req2 burst stalled by a full FIFO for 5 cycles
      add(0, 4'b0100, 4'b0000, 1, 8'h20, 4'b0000, 0, 3, 0);
      add(0, 4'b0100, 4'b0000, 1, 8'h20, 4'b0100, 1, 2, 1);
      for (int k = 0; k < 5; k++) add(0, 4'b0100, 4'b0000, 0, 8'h21, 4'b0000, 0, 2, 1);
      add(0, 4'b0100, 4'b0000, 1, 8'h21, 4'b0100, 1, 2, 1);
      add(0, 4'b0100, 4'b0100, 1, 8'h22, 4'b0100, 1, 2, 1);
      add(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2, 0);
      // reset after beat 2 of a 4-beat req1 burst
      add(0, 4'b0010, 4'b0000, 1, 8'h30, 4'b0000, 0, 2, 0);
      add(0, 4'b0010, 4'b0000, 1, 8'h30, 4'b0010, 1, 1, 1);
      add(0, 4'b0010, 4'b0000, 1, 8'h31, 4'b0010, 1, 1, 1);
      add(1, 4'b0010, 4'b0000, 1, 8'h32, 4'b0000, 0, 1, 1);
      add(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 0, 0);
      // pointer back at N-1: req0 then req3, single-beat bursts
      add(0, 4'b1001, 4'b0000, 1, 8'h33, 4'b0000, 0, 0, 0);
      add(0, 4'b1001, 4'b0001, 1, 8'h33, 4'b0001, 1, 0, 1);
      add(0, 4'b1000, 4'b0000, 1, 8'h34, 4'b0000, 0, 0, 0);
      add(0, 4'b1000, 4'b1000, 1, 8'h34, 4'b1000, 1, 3, 1);
      add(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 3, 0);
      // owner drops valid for 10 cycles while req2 waits: grant held
      add(0, 4'b0010, 4'b0000, 1, 8'h40, 4'b0000, 0, 3, 0);
      add(0, 4'b0010, 4'b0000, 1, 8'h40, 4'b0010, 1, 1, 1);
      for (int k = 0; k < 10; k++) add(0, 4'b0100, 4'b0000, 1, 8'h41, 4'b0010, 0, 1, 1);
      add(0, 4'b0110, 4'b0010, 1, 8'h41, 4'b0010, 1, 1, 1);
      add(0, 4'b0100, 4'b0000, 1, 8'h42, 4'b0000, 0, 1, 0);
      add(0, 4'b0100, 4'b0100, 1, 8'h42, 4'b0100, 1, 2, 1);
      add(0, 4'b0000, 4'b0000, 1, 8'h00, 4'b0000, 0, 2, 0);

      foreach (tbl[k]) begin
         @(negedge clk);
         rst = tbl[k].rst; s_valid = tbl[k].v; s_last = tbl[k].l;
         fifo_wr_vld = tbl[k].wv; drive_data(tbl[k].dat);
         #2;
         chk($sformatf("row%0d s_ready", k), 64'(s_ready), 64'(tbl[k].e_rdy));
         chk($sformatf("row%0d wr_en", k), 64'(fifo_wr_en), 64'(tbl[k].e_wen));
         chk($sformatf("row%0d grant_id", k), 64'(grant_id), 64'(tbl[k].e_g));
         chk($sformatf("row%0d busy", k), 64'(busy), 64'(tbl[k].e_busy));
         chk($sformatf("row%0d timeout_err", k), 64'(timeout_err), 64'(0));
         if (tbl[k].e_wen)
            chk($sformatf("row%0d wr_data", k), 64'(fifo_wr_data),
                64'({8'(tbl[k].e_g), 16'h0000, tbl[k].dat}));
      end

`ifdef IPML_WR_ARB_WATCHDOG_EN
      // Owner goes silent for TO cycles: released with a one-cycle error pulse.
      @(negedge clk); rst = 1'b1; s_valid = '0; s_last = '0; fifo_wr_vld = 1'b1;
      @(negedge clk); rst = 1'b0; s_valid = 4'b0010; drive_data(8'h50);
      @(negedge clk);
      #2 chk("wd first beat", 64'({grant_id, fifo_wr_en}), 64'({2'd1, 1'b1}));
      for (int k = 0; k < TO; k++) begin
         @(negedge clk); s_valid = 4'b0100;
         #2 chk($sformatf("wd hold%0d", k), 64'({busy, timeout_err}), 64'({1'b1, 1'b0}));
      end
      @(negedge clk);
      #2 chk("wd release", 64'({busy, timeout_err}), 64'({1'b0, 1'b1}));
      @(negedge clk);
      #2 chk("wd next grant", 64'({grant_id, busy, timeout_err}), 64'({2'd2, 1'b1, 1'b0}));
`endif

      // Randomized traffic against the burst-level model
      @(negedge clk); rst = 1'b1; s_valid = '0; s_last = '0;
      owner = -1; m_grant = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) begin rem[i] = 0; bnum[i] = 0; beat[i] = 0; pres[i] = 0; end
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && $urandom_range(3) == 0) begin
               rem[i] = $urandom_range(4, 1); beat[i] = 0;
            end
            if (rem[i] > 0 && !pres[i] && $urandom_range(9) < 7) pres[i] = 1;
            s_valid[i] = pres[i];
            s_last[i]  = pres[i] && (rem[i] == 1);
            s_data[i*DW +: DW] = {8'(i), 8'(bnum[i]), 16'(beat[i])};
         end
         fifo_wr_vld = ($urandom_range(3) != 0);
         #2;
         e_rdy = '0; e_wen = 1'b0; e_data = '0;
         if (owner >= 0) begin
            e_rdy[owner] = fifo_wr_vld;
            e_wen = pres[owner] && fifo_wr_vld;
            e_data = {8'(owner), 8'(bnum[owner]), 16'(beat[owner])};
         end
         chk($sformatf("rnd%0d s_ready", c), 64'(s_ready), 64'(e_rdy));
         chk($sformatf("rnd%0d wr_en", c), 64'(fifo_wr_en), 64'(e_wen));
         chk($sformatf("rnd%0d grant_id", c), 64'(grant_id), 64'(m_grant));
         chk($sformatf("rnd%0d busy", c), 64'(busy), 64'(owner >= 0));
         if (e_wen) chk($sformatf("rnd%0d wr_data", c), 64'(fifo_wr_data), 64'(e_data));
         if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
               cand = (m_last + k) % N;
               if (pres[cand]) begin
                  owner = cand; m_grant = cand; m_last = cand;
                  break;
               end
            end
         end else if (e_wen) begin
            beat[owner]++; rem[owner]--; pres[owner] = 0;
            if (rem[owner] == 0) begin
               bnum[owner]++;
               owner = -1;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
